// File: rtl/scan_mux_pkg.sv
// ----------------------------------------------------------------------------
// scan_mux_pkg
// Shared definitions for the scan_mux_reg channel selector:
//   - mode encodings for the 'mode' input
//   - FSM state enumeration
//   - clog2_min1(): width helper that never returns 0. This lets counters
//     sized from a parameter that may be 1 still be legal vectors.
// ----------------------------------------------------------------------------
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

    // Smallest w >= 1 such that 2**w >= value.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage : scan_mux_pkg

// File: rtl/scan_mux_reg_sel.sv
// ----------------------------------------------------------------------------
// mux_slice_sel
// Combinational N_IN x WIDTH selector with per-channel valid.
// An index that names no channel (possible when N_IN is not a power of two)
// yields data 0 and valid 0, so the caller never latches garbage.
//
// Ports:
//   in_bus_i   [N_IN*WIDTH] channel k at bits [k*WIDTH +: WIDTH]
//   in_valid_i [N_IN]       per-channel valid
//   sel_i      [SEL_W]      channel index
//   data_o     [WIDTH]      selected channel data (0 if out of range)
//   valid_o                 selected channel valid (0 if out of range)
// ----------------------------------------------------------------------------
module mux_slice_sel #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_IN*WIDTH-1:0] in_bus_i,
    input  logic [N_IN-1:0]       in_valid_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o
);

    logic [WIDTH-1:0] slice_w [N_IN];

    // Unpack the flat bus into one word per channel.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_slice
            assign slice_w[gi] = in_bus_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Defaults cover the out-of-range case: no match leaves data/valid at 0.
    always_comb begin
        data_o  = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o  = slice_w[k];
                valid_o = in_valid_i[k];
            end
        end
    end

endmodule : mux_slice_sel

// File: rtl/scan_mux_reg.sv
// ----------------------------------------------------------------------------
// scan_mux_reg
// Registered N_IN-to-1 channel selector with valid/ready output handshake and
// an auto-scan mode that round-robins the channels, spending DWELL loads on
// each one.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   mode       0 = manual select (sel_in), 1 = auto-scan
//   sel_in     channel index used in manual mode
//   in_bus     N_IN channels of WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   out_data   registered selected data
//   out_sel    channel index out_data came from
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes the word when out_valid & out_ready
//
// The output register loads whenever it is empty or being drained
// (load = !out_valid | out_ready); otherwise everything holds, so a stalled
// word is never overwritten.
// ----------------------------------------------------------------------------
module scan_mux_reg #(
    parameter  int WIDTH = 8,
    parameter  int N_IN  = 4,
    parameter  int DWELL = 4,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic [N_IN*WIDTH-1:0] in_bus,
    input  logic [N_IN-1:0]       in_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    import scan_mux_pkg::*;

    localparam int                CNT_W      = clog2_min1(DWELL);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST   = SEL_W'(N_IN - 1);

    // FSM and scan counters
    state_e            state_q, state_d;
    logic [SEL_W-1:0]  scan_sel_q, scan_sel_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;

    // Output register
    logic [WIDTH-1:0]  out_data_q;
    logic [SEL_W-1:0]  out_sel_q;
    logic              out_valid_q;

    // Datapath
    logic [SEL_W-1:0]  cur_sel;
    logic [WIDTH-1:0]  mux_data;
    logic              mux_valid;
    logic              load;

    // Manual mode follows sel_in within the same cycle; scan mode uses the
    // registered round-robin index.
    always_comb begin
        cur_sel = sel_in;
        if (state_q == ST_SCAN) begin
            cur_sel = scan_sel_q;
        end
    end

    mux_slice_sel #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_sel (
        .in_bus_i   (in_bus),
        .in_valid_i (in_valid),
        .sel_i      (cur_sel),
        .data_o     (mux_data),
        .valid_o    (mux_valid)
    );

    assign load = !out_valid_q || out_ready;

    // Next-state logic. A mode change and a load in the same cycle are
    // independent: the load (in the sequential block) uses the current
    // state's cur_sel, and the new state applies from the next cycle.
    always_comb begin
        state_d    = state_q;
        scan_sel_d = scan_sel_q;
        dwell_d    = dwell_q;
        case (state_q)
            ST_MANUAL: begin
                // Counters are held at zero so SCAN always starts at
                // channel 0 with a fresh dwell.
                scan_sel_d = '0;
                dwell_d    = '0;
                if (mode == MODE_SCAN) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (mode == MODE_MANUAL) begin
                    state_d    = ST_MANUAL;
                    scan_sel_d = '0;
                    dwell_d    = '0;
                end else if (load) begin
                    // Every load counts, valid or not, so an idle channel
                    // cannot hold the scan. Stalls (no load) freeze it.
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (scan_sel_q == SEL_LAST) begin
                            scan_sel_d = '0;
                        end else begin
                            scan_sel_d = scan_sel_q + 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_MANUAL;
                scan_sel_d = '0;
                dwell_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_MANUAL;
            scan_sel_q  <= '0;
            dwell_q     <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_sel_q <= scan_sel_d;
            dwell_q    <= dwell_d;
            if (load) begin
                out_data_q  <= mux_data;
                out_sel_q   <= cur_sel;
                out_valid_q <= mux_valid;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule : scan_mux_reg

// File: tb/tb_scan_mux_reg.sv
// ----------------------------------------------------------------------------
// tb_scan_mux_reg
// Directed bench for scan_mux_reg. Two instances share clk/rst:
//   dut   : WIDTH=8, N_IN=4, DWELL=4
//   dut3  : WIDTH=8, N_IN=3, DWELL=1 (out-of-range select, per-load advance)
// Inputs are driven 1 time unit after the rising edge, outputs are read at the
// same point, i.e. they reflect the edge just taken.
// ----------------------------------------------------------------------------
module tb_scan_mux_reg;

    logic        clk;
    logic        rst;

    logic        mode;
    logic [1:0]  sel_in;
    logic [31:0] in_bus;
    logic [3:0]  in_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] bus3;
    logic [2:0]  valid3;
    logic [7:0]  data3;
    logic [1:0]  osel3;
    logic        ovalid3;
    logic        ready3;

    int n_checks;
    int n_fail;

    logic [7:0] exp_b [4];
    logic [7:0] exp3_b [3];

    scan_mux_reg #(.WIDTH(8), .N_IN(4), .DWELL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel_in    (sel_in),
        .in_bus    (in_bus),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    scan_mux_reg #(.WIDTH(8), .N_IN(3), .DWELL(1)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel_in    (sel3),
        .in_bus    (bus3),
        .in_valid  (valid3),
        .out_data  (data3),
        .out_sel   (osel3),
        .out_valid (ovalid3),
        .out_ready (ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a fixed number of cycles, this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t  n4: sel=%0d data=%h valid=%b ready=%b | n3: sel=%0d data=%h valid=%b",
                 $time, out_sel, out_data, out_valid, out_ready, osel3, data3, ovalid3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_data !== 8'h00 || out_sel !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_n4: got data=%h sel=%0d valid=%b, required data=00 sel=0 valid=0",
                     out_data, out_sel, out_valid);
        end
        n_checks++;
        if (data3 !== 8'h00 || osel3 !== 2'd0 || ovalid3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_n3: got data=%h sel=%0d valid=%b, required data=00 sel=0 valid=0",
                     data3, osel3, ovalid3);
        end
        rst = 1'b0;
    endtask

    task automatic test_manual();
        for (int s = 0; s < 4; s++) begin
            sel_in = 2'(s);
            tick();
            n_checks++;
            if (out_data !== exp_b[s] || out_sel !== 2'(s) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL manual_sel%0d: got data=%h sel=%0d valid=%b, required data=%h sel=%0d valid=1",
                         s, out_data, out_sel, out_valid, exp_b[s], s);
            end
        end
    endtask

    task automatic test_backpressure();
        sel_in = 2'd2;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_bus = {8'h10 + 8'(c), 8'h20 + 8'(c), 8'h30 + 8'(c), 8'h40 + 8'(c)};
            tick();
            n_checks++;
            if (out_data !== 8'hCC || out_sel !== 2'd2 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got data=%h sel=%0d valid=%b, required data=CC sel=2 valid=1",
                         c, out_data, out_sel, out_valid);
            end
        end
        // Last bus written is {14,24,34,44}; channel 2 carries 8'h24.
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_data !== 8'h24 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got data=%h sel=%0d valid=%b, required data=24 sel=2 valid=1",
                     out_data, out_sel, out_valid);
        end
        in_bus = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    endtask

    task automatic test_scan();
        int ch;
        int exp_seq [7];
        exp_seq = '{0, 0, 1, 1, 1, 1, 2};
        sel_in = 2'd3;
        mode   = 1'b1;
        tick();
        n_checks++;
        if (out_sel !== 2'd3 || out_data !== 8'hDD) begin
            n_fail++;
            $display("FAIL scan_entry_manual: got sel=%0d data=%h, required sel=3 data=DD",
                     out_sel, out_data);
        end
        for (int i = 0; i < 18; i++) begin
            ch = (i / 4) % 4;
            tick();
            n_checks++;
            if (out_sel !== 2'(ch) || out_data !== exp_b[ch] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_load%0d: got sel=%0d data=%h valid=%b, required sel=%0d data=%h valid=1",
                         i, out_sel, out_data, out_valid, ch, exp_b[ch]);
            end
        end
        // Channel 0 has had 2 of its 4 loads; stall for 3 cycles.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_stall%0d: got sel=%0d valid=%b, required sel=0 valid=1",
                         c, out_sel, out_valid);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (out_sel !== 2'(exp_seq[i])) begin
                n_fail++;
                $display("FAIL scan_resume%0d: got sel=%0d, required sel=%0d",
                         i, out_sel, exp_seq[i]);
            end
        end
    endtask

    task automatic test_scan_invalid();
        int  ch;
        logic exp_v;
        in_valid = 4'b1011;
        sel_in   = 2'd3;
        mode     = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        n_checks++;
        if (out_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL toggle_manual_load: got sel=%0d, required sel=3", out_sel);
        end
        for (int i = 0; i < 17; i++) begin
            ch    = (i / 4) % 4;
            exp_v = (ch != 2);
            tick();
            n_checks++;
            if (out_sel !== 2'(ch) || out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL scan_invalid%0d: got sel=%0d valid=%b, required sel=%0d valid=%b",
                         i, out_sel, out_valid, ch, exp_v);
            end
        end
        in_valid = 4'b1111;
    endtask

    task automatic test_reset_stall();
        sel_in = 2'd0;
        mode   = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        tick();
        n_checks++;
        if (out_sel !== 2'd2 || out_data !== 8'hCC) begin
            n_fail++;
            $display("FAIL rst_setup: got sel=%0d data=%h, required sel=2 data=CC", out_sel, out_data);
        end
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_midstall: got data=%h sel=%0d valid=%b, required data=00 sel=0 valid=0",
                     out_data, out_sel, out_valid);
        end
        // mode stays 1: a MANUAL state loads sel_in=1 here, SCAN would give 0.
        rst    = 1'b0;
        sel_in = 2'd1;
        tick();
        n_checks++;
        if (out_sel !== 2'd1 || out_data !== 8'hBB || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_state_manual: got data=%h sel=%0d valid=%b, required data=BB sel=1 valid=1",
                     out_data, out_sel, out_valid);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_sel !== 2'd0 || out_data !== 8'hAA) begin
            n_fail++;
            $display("FAIL rst_then_scan: got data=%h sel=%0d, required data=AA sel=0", out_data, out_sel);
        end
    endtask

    task automatic test_n3();
        int exp_s [5];
        exp_s = '{0, 1, 2, 0, 1};
        sel3 = 2'd3;
        tick();
        n_checks++;
        if (data3 !== 8'h00 || ovalid3 !== 1'b0 || osel3 !== 2'd3) begin
            n_fail++;
            $display("FAIL n3_out_of_range: got data=%h sel=%0d valid=%b, required data=00 sel=3 valid=0",
                     data3, osel3, ovalid3);
        end
        sel3 = 2'd1;
        tick();
        n_checks++;
        if (data3 !== 8'h22 || ovalid3 !== 1'b1 || osel3 !== 2'd1) begin
            n_fail++;
            $display("FAIL n3_manual1: got data=%h sel=%0d valid=%b, required data=22 sel=1 valid=1",
                     data3, osel3, ovalid3);
        end
        mode3 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (osel3 !== 2'(exp_s[i]) || data3 !== exp3_b[exp_s[i]]) begin
                n_fail++;
                $display("FAIL n3_dwell1_%0d: got sel=%0d data=%h, required sel=%0d data=%h",
                         i, osel3, data3, exp_s[i], exp3_b[exp_s[i]]);
            end
        end
        // Load in the same cycle as mode 1->0 still uses the scan index (2).
        mode3 = 1'b0;
        sel3  = 2'd0;
        tick();
        n_checks++;
        if (osel3 !== 2'd2) begin
            n_fail++;
            $display("FAIL n3_mode_change_load: got sel=%0d, required sel=2", osel3);
        end
        mode3 = 1'b1;
        sel3  = 2'd2;
        tick();
        tick();
        n_checks++;
        if (osel3 !== 2'd0 || data3 !== 8'h11) begin
            n_fail++;
            $display("FAIL n3_scan_restart: got sel=%0d data=%h, required sel=0 data=11", osel3, data3);
        end
        tick();
        n_checks++;
        if (osel3 !== 2'd1) begin
            n_fail++;
            $display("FAIL n3_scan_restart_next: got sel=%0d, required sel=1", osel3);
        end
        mode3 = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_b     = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp3_b    = '{8'h11, 8'h22, 8'h33};
        rst       = 1'b1;
        mode      = 1'b0;
        sel_in    = 2'd0;
        in_bus    = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        mode3     = 1'b0;
        sel3      = 2'd0;
        bus3      = {8'h33, 8'h22, 8'h11};
        valid3    = 3'b111;
        ready3    = 1'b1;

        test_reset();
        test_manual();
        test_backpressure();
        test_scan();
        test_scan_invalid();
        test_reset_stall();
        test_n3();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_scan_mux_reg
